// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter in front of the FIFO write port
module fifo_wr_arbiter #(
   parameter int DWIDTH = 8,
   parameter int NREQ   = 4,
   parameter int BURST  = 4
) (
   input  logic                     wclk,
   input  logic                     wrst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DWIDTH-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     wfull,
   output logic                     w_en,
   output logic [DWIDTH-1:0]        wdata,
   output logic [NREQ-1:0]          grant,
   output logic                     busy
);

   localparam int LW = $clog2(NREQ);
   localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t          state;
   logic [LW-1:0]   last;
   logic [CW-1:0]   cnt;
   logic [LW-1:0]   owner;
   logic            owner_valid;
   logic [LW-1:0]   pick;
   logic            found;
   int              idx;

   always_comb begin
      owner = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) owner = LW'(i);
      end
   end

   assign owner_valid = |(grant & req_valid);
   assign w_en        = owner_valid & ~wfull;
   assign req_ready   = wfull ? '0 : grant;
   assign wdata       = req_data[int'(owner)*DWIDTH +: DWIDTH];
   assign busy        = (state == S_GRANT);

   // Scan starts just past the previous owner so it is served last.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last) + k) % NREQ;
         if (!found && req_valid[idx[LW-1:0]]) begin
            found = 1'b1;
            pick  = idx[LW-1:0];
         end
      end
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state <= S_IDLE;
         grant <= '0;
         cnt   <= '0;
         last  <= LW'(NREQ - 1);
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  state <= S_GRANT;
                  grant <= NREQ'(1) << pick;
                  cnt   <= '0;
               end
            end
            S_GRANT: begin
               if (!owner_valid || (w_en && cnt == CW'(BURST - 1))) begin
                  state <= S_IDLE;
                  last  <= owner;
                  grant <= '0;
                  cnt   <= '0;
               end else if (w_en) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               grant <= '0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized and directed bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

   localparam int DW = 8;
   localparam int N  = 4;
   localparam int B  = 4;

   logic            wclk = 1'b0;
   logic            wrst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            wfull;
   logic            w_en;
   logic [DW-1:0]   wdata;
   logic [N-1:0]    grant;
   logic            busy;

   fifo_wr_arbiter #(.DWIDTH(DW), .NREQ(N), .BURST(B)) dut (
      .wclk      (wclk),
      .wrst      (wrst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wfull     (wfull),
      .w_en      (w_en),
      .wdata     (wdata),
      .grant     (grant),
      .busy      (busy)
   );

   always #5 wclk = ~wclk;

   int vectors     = 0;
   int miscompares = 0;
   int m_owner;
   int m_cnt;
   int m_last;
   int writes[N];
   int dut_writes = 0;
   int base;
   logic [N-1:0] seq[$];
   logic [N-1:0] prev;

   always @(posedge wclk) if (!wrst && w_en) dut_writes++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_cnt   = 0;
      m_last  = N - 1;
   endtask

   task automatic clear_writes();
      for (int i = 0; i < N; i++) writes[i] = 0;
   endtask

   // Inputs are set at the falling edge; outputs checked 1 time unit later.
   task automatic cycle();
      bit ow_valid, xfer, found;
      int idx;
      #1;
      ow_valid = (m_owner >= 0) && req_valid[m_owner];
      xfer     = ow_valid && !wfull;
      check("grant", 32'(grant), (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("w_en", 32'(w_en), 32'(xfer));
      check("req_ready", 32'(req_ready), (m_owner >= 0 && !wfull) ? 32'(1 << m_owner) : 32'd0);
      if (xfer) begin
         check("wdata", 32'(wdata), 32'(req_data[m_owner*DW +: DW]));
         writes[m_owner]++;
      end
      if (m_owner < 0) begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (!found && req_valid[idx]) begin
               found   = 1'b1;
               m_owner = idx;
               m_cnt   = 0;
            end
         end
      end else if (!ow_valid || (xfer && m_cnt == B - 1)) begin
         m_last  = m_owner;
         m_owner = -1;
         m_cnt   = 0;
      end else if (xfer) begin
         m_cnt++;
      end
      @(negedge wclk);
   endtask

   task automatic reset_pulse();
      #2 wrst = 1'b1;
      #1;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_w_en", 32'(w_en), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      @(negedge wclk);
      wrst = 1'b0;
      model_reset();
   endtask

   initial begin
      wrst      = 1'b1;
      req_valid = '0;
      req_data  = '0;
      wfull     = 1'b0;
      model_reset();
      clear_writes();
      @(negedge wclk);
      wrst = 1'b0;
      cycle();

      // Round-robin with all requesters valid
      req_valid = 4'b1111;
      req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      prev = '0;
      for (int c = 0; c < 22; c++) begin
         if (c == 20) begin
            for (int i = 0; i < N; i++) check("rr_writes", 32'(writes[i]), 32'd4);
         end
         if (grant != '0 && prev == '0) seq.push_back(grant);
         prev = grant;
         cycle();
      end
      check("rr_len", 32'(seq.size()), 32'd5);
      if (seq.size() >= 5) begin
         check("rr_g0", 32'(seq[0]), 32'h1);
         check("rr_g1", 32'(seq[1]), 32'h2);
         check("rr_g2", 32'(seq[2]), 32'h4);
         check("rr_g3", 32'(seq[3]), 32'h8);
         check("rr_g4", 32'(seq[4]), 32'h1);
      end
      req_valid = '0;
      repeat (2) cycle();

      // Full stall on requester 2
      clear_writes();
      req_valid = 4'b0100;
      repeat (3) cycle();
      wfull = 1'b1;
      repeat (5) cycle();
      wfull = 1'b0;
      repeat (2) cycle();
      req_valid = '0;
      cycle();
      check("stall_writes", 32'(writes[2]), 32'd4);
      check("stall_idle", 32'(grant), 32'd0);

      // Early drop by requester 1 while requester 3 waits
      clear_writes();
      req_valid = 4'b0010;
      repeat (2) cycle();
      req_valid = 4'b1000;
      repeat (2) cycle();
      check("drop_grant", 32'(grant), 32'h8);
      check("drop_writes", 32'(writes[1]), 32'd1);
      req_valid = '0;
      repeat (2) cycle();

      // Lone requester 0, then requester 3 joins mid-burst
      req_valid = 4'b0001;
      repeat (7) cycle();
      req_valid = 4'b1001;
      repeat (4) cycle();
      check("rot_next", 32'(grant), 32'h8);
      req_valid = '0;
      repeat (6) cycle();

      // Reset after two writes of a burst
      req_valid = 4'b1111;
      cycle();
      base = dut_writes;
      repeat (2) cycle();
      reset_pulse();
      check("rst_fifo_words", 32'(dut_writes - base), 32'd2);
      cycle();
      check("rst_restart", 32'(grant), 32'h1);

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) req_valid[i] = ($urandom % 10) < 7;
         req_data = N*DW'($urandom);
         wfull    = ($urandom % 5) == 0;
         if ($urandom % 200 == 0) reset_pulse();
         else cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of the team's dual-clock FIFO among NREQ requesters in the write-clock domain. Each requester presents a valid/data stream. The arbiter grants one requester at a time for a burst of up to BURST words and drives the FIFO's `w_en`/`wdata`, honouring `wfull`. It sits directly in front of the FIFO write port and contains no storage beyond grant, pointer and burst-count state.

## Interface
- `DWIDTH`, 8, data word width; must match the FIFO.
- `NREQ`, 4, number of requesters; valid range 2..16.
- `BURST`, 4, maximum words per grant; must be ≥1.

- `wclk`  in  1  write-domain clock; all state updates on its rising edge.
- `wrst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NREQ  bit i: requester i has a word on its data lane.
- `req_data`  in  NREQ*DWIDTH  requester i data at `[i*DWIDTH +: DWIDTH]`.
- `req_ready`  out  NREQ  bit i: word i is accepted this cycle when `req_valid[i]` is also high.
- `wfull`  in  1  FIFO full flag.
- `w_en`  out  1  FIFO write enable.
- `wdata`  out  DWIDTH  FIFO write data.
- `grant`  out  NREQ  registered one-hot owner; all zero when idle.
- `busy`  out  1  high while a grant is held.

## Operation
- **State machine:** two states, IDLE and GRANT.
- **Registers:**
  - `grant` (one-hot).
  - `last`: index of the most recent owner, width clog2(NREQ).
  - `cnt`: burst count, width max(1, clog2(BURST)).
- **Reset values:** state=IDLE, `grant`=0, `cnt`=0, `last`=NREQ-1, so requester 0 has first priority.
- **IDLE:**
  - If any `req_valid` is high, select the first set bit scanning from `(last+1) mod NREQ` upward with wrap.
  - Next state GRANT; `grant` = one-hot of the selection; `cnt` = 0.
  - If no `req_valid` is high, stay in IDLE.
- **GRANT, owner g:**
  - `req_ready[g]` = !wfull. All other `req_ready` bits = 0.
  - `w_en` = `req_valid[g]` & !wfull.
  - `wdata` = lane g. `wdata` is don't-care when `w_en`=0; the implementation drives lane g.
- **Transfer:** occurs when `w_en`=1. `cnt` increments on each transfer.
- **Release:** go to IDLE, set `last`=g, clear `grant` and `cnt` when either condition holds:
  - a transfer occurs with `cnt` == BURST-1, or
  - `req_valid[g]`=0.
- **Stall:**
  - `req_valid[g]`=1 with `wfull`=1 holds the grant with no transfer and no `cnt` change.
  - There is no timeout.
- **Requester drops valid mid-burst:** the grant is released and the remaining burst allowance is forfeited.
- **Non-owner requests:** ignored until the next IDLE arbitration.
- **Combinational paths:** `w_en`, `wdata` and `req_ready` are combinational from state, `req_valid`, `req_data` and `wfull`. There are no paths from `req_valid` to `grant`.
- **Outputs:** `busy` = (state == GRANT).
- **Reset mid-burst:**
  - `grant`, `busy`, `w_en` and `req_ready` go to 0 asynchronously.
  - Words already written remain in the FIFO.
  - The partial burst count is discarded.

## Timing
- **Grant latency:** `req_valid` high in IDLE during cycle 0 → `grant` and `busy` high from the edge ending cycle 0. The first `w_en` is in cycle 1 if `wfull`=0.
- **Burst length:** a full burst occupies BURST consecutive write cycles.
- **Release bubble:** after release there is exactly one IDLE cycle (`w_en`=0) before the next grant. Sustained throughput is BURST/(BURST+1) words per cycle.
- **Valid drop:** a requester deasserting `req_valid` while owning the grant costs one cycle. That cycle ends GRANT, followed by one IDLE cycle.
- **`wfull` response:** `wfull` rising blocks `w_en` in the same cycle; no write is issued while `wfull`=1.
- **Simultaneous events:** a transfer on the last burst word in the same cycle as other requesters asserting → those requesters arbitrate in the following IDLE cycle, with the releasing requester at lowest priority.

## Test plan
- **Reset state:** assert `wrst` asynchronously between clock edges → `grant`=0, `busy`=0, `w_en`=0 immediately. After release with `req_valid`=4'b1111, the first grant is 4'b0001.
- **Round-robin:** `req_valid`=4'b1111 held, BURST=4, `wfull`=0, data lane i = 8'hA0+i.
  - Required grant sequence: 0001, 0010, 0100, 1000, 0001.
  - Each grant carries exactly 4 writes of the lane's value, with one `w_en`=0 cycle between grants.
- **Full stall:** requester 2 only, `wfull` forced high after 2 writes for 5 cycles, then low.
  - Required: `grant`=0100 held throughout, `w_en`=0 during the stall, then exactly 2 more writes, then release.
- **Early drop:** requester 1 drops `req_valid` after 1 write while requester 3 is valid.
  - Required: release next edge, one IDLE cycle, then `grant`=1000.
  - Total writes from requester 1 = 1.
- **Priority rotation:** only requester 0 valid for two bursts.
  - Required: re-granted to 0 after each IDLE cycle (a lone requester is never starved by `last`).
  - When requester 3 becomes valid mid-burst, it is granted next.
- **Reset mid-burst:** assert `wrst` after 2 of 4 writes → FIFO holds 2 words and `w_en` drops the same cycle. After reset, arbitration restarts from requester 0.
